mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Shares one combinational 16x16 unsigned `mult` array between two requesters. Each requester offers operands over a valid/ready handshake. The block registers the operands and holds them stable for a fixed settle window, which treats the deep array as a multicycle path. It then captures the 32-bit product as `hi`/`lo` and returns it with the requester ID over a valid/ready response channel. It sits between the two issue ports of the datapath and the single multiplier instance.

## Interface
- `SETTLE_CYCLES`, default 2: number of cycles the operands are held at the array before the product is sampled. Legal range is 1..15; 0 is illegal.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has operands.
- `req0_ready`  out  1  requester 0 transfer accepted this cycle.
- `req0_a`, `req0_b`  in  16 each  requester 0 operands.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: as above, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_id`  out  1  requester that owns the result.
- `rsp_hi`, `rsp_lo`  out  16 each  upper and lower halves of the product.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE → SETTLE on an accepted request.
  - SETTLE → DONE when the settle counter reaches `SETTLE_CYCLES-1`.
  - DONE → IDLE on `rsp_valid && rsp_ready`.
- Arbitration is round-robin, using register `last_id`.
  - In IDLE with both valids high, grant the requester not equal to `last_id`.
  - With one valid high, grant that requester.
  - `last_id` updates to the granted ID on accept.
- `reqN_ready` is combinational: `(state==IDLE) && granted==N`. At most one ready is high per cycle. Ready never depends on the other channel's ready.
- Accept is `reqN_valid && reqN_ready`. On accept:
  - `op_a`/`op_b` load from the granted port.
  - `rsp_id` loads the granted ID.
  - The counter clears.
- The `mult` instance is driven only from `op_a`/`op_b`. The operands must not change outside an accept.
- On the SETTLE→DONE edge, `rsp_hi`/`rsp_lo` capture the `mult` hi/lo outputs.
- Results are unsigned: `{rsp_hi, rsp_lo} = op_a * op_b`, full 32 bits, with no truncation.
- In DONE, `rsp_valid`=1. `rsp_hi`, `rsp_lo` and `rsp_id` are held stable until the handshake completes. Backpressure is unlimited.
- Requests arriving while `busy` wait with `ready` low. Requesters must hold valid and operands until accepted.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, `busy`=0, `rsp_valid`=0.
  - `rsp_id`=0, `rsp_hi`=0, `rsp_lo`=0.
  - `op_a`=0, `op_b`=0, counter=0.
  - `last_id`=1, so requester 0 wins the first tie.
- Latency: an accept at edge T gives `rsp_valid` high after edge `T+SETTLE_CYCLES`.
- The response handshake at edge R returns the FSM to IDLE. The next accept is possible at edge R+1.
- Minimum issue interval is `SETTLE_CYCLES+2` cycles.
- Simultaneous events:
  - A new request during DONE is not accepted in the same cycle as the response handshake.
  - A `reqN_valid` drop while not ready is legal and has no effect.
- Reset mid-operation: any in-flight transaction is discarded and no response is produced. After `rst_n` rises, the first tie goes to requester 0.

## Structure
- Shared package `mult_pkg` holds:
  - the state encoding: IDLE=2'd0, SETTLE=2'd1, DONE=2'd2;
  - the default `SETTLE_CYCLES`;
  - the operand width constant 16.
- One sub-module, the existing `mult` (ports hi, lo, A, B), instantiated once inside.
- Counter width is 4 bits.

## Test plan
- Requester 0 sends A=0x1234, B=0x5678 → `rsp_id`=0, hi=0x0626, lo=0x0060. `rsp_valid` rises exactly `SETTLE_CYCLES` edges after accept.
- Requester 1 sends 0xFFFF×0xFFFF → hi=0xFFFE, lo=0x0001, `rsp_id`=1.
- Both valid from reset with 0x0003×0x0005 (req0) and 0x0007×0x0009 (req1). Both kept asserted →
  - req0 is served first (lo=0x000F), then req1 (lo=0x003F);
  - a third tie is granted to req0.
- Hold `rsp_ready`=0 for 10 cycles after `rsp_valid` → outputs are stable, no new accept occurs, and `req0_ready`/`req1_ready` stay 0.
- Deassert `rst_n` during SETTLE → all outputs are zero immediately. After release, no response appears, and a new 0x0000×0x1234 request returns hi=lo=0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier arbiter: FSM encoding,
// operand width, settle-window default and counter width.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int DATA_W           = 16;
    localparam int CNT_W            = 4;
    localparam int SETTLE_CYCLES_DEF = 2;

endpackage

// File: rtl/mult.sv
// Combinational 16x16 unsigned array multiplier; deep enough that callers
// treat it as a multicycle path.
module mult
    import mult_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    logic [2*DATA_W-1:0] prod;

    assign prod     = (2*DATA_W)'(A) * (2*DATA_W)'(B);
    assign {hi, lo} = prod;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multicycle multiplier between two
// valid/ready requesters; returns the tagged product on a response channel.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_hi,
    output logic [DATA_W-1:0] rsp_lo,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_hi_q;
    logic [DATA_W-1:0] rsp_lo_q;
    logic              last_id_q;

    logic              grant;
    logic              accept;
    logic [DATA_W-1:0] mult_hi;
    logic [DATA_W-1:0] mult_lo;

    // A tie goes to whoever was not served last; otherwise the lone requester.
    assign grant  = (req0_valid && req1_valid) ? ~last_id_q : req1_valid;

    assign req0_ready = (state_q == IDLE) && (grant == 1'b0);
    assign req1_ready = (state_q == IDLE) && (grant == 1'b1);
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_hi    = rsp_hi_q;
    assign rsp_lo    = rsp_lo_q;

    // The array sees only the held operand registers, so its inputs are
    // stable for the whole settle window.
    mult u_mult (
        .A  (op_a_q),
        .B  (op_b_q),
        .hi (mult_hi),
        .lo (mult_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rsp_id_q  <= 1'b0;
            rsp_hi_q  <= '0;
            rsp_lo_q  <= '0;
            last_id_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= SETTLE;
                        cnt_q     <= '0;
                        op_a_q    <= grant ? req1_a : req0_a;
                        op_b_q    <= grant ? req1_b : req0_b;
                        rsp_id_q  <= grant;
                        last_id_q <= grant;
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= DONE;
                        rsp_hi_q <= mult_hi;
                        rsp_lo_q <= mult_lo;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: table of single transactions plus
// hand-written tie, backpressure and mid-operation reset sequences.
module tb_mult_arbiter;

    localparam int S = 3;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [15:0] rsp_hi, rsp_lo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] hi;
        logic [15:0] lo;
    } vec_t;

    mult_arbiter #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_hi     (rsp_hi),
        .rsp_lo     (rsp_lo),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic wait_ready(input logic id, output bit ok);
        int n = 0;
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (n < 50);
    endtask

    task automatic wait_rsp(output int lat, output bit ok);
        int n = 0;
        while (!rsp_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n;
        ok  = (n < 60);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input string tag, input vec_t v);
        bit ok;
        int lat;
        if (v.id) begin
            req1_a = v.a; req1_b = v.b; req1_valid = 1'b1;
        end else begin
            req0_a = v.a; req0_b = v.b; req0_valid = 1'b1;
        end
        wait_ready(v.id, ok);
        chk({tag, "_ready_seen"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_rsp(lat, ok);
        chk({tag, "_latency"}, 32'(lat), 32'(S));
        chk({tag, "_id"}, 32'(rsp_id), 32'(v.id));
        chk({tag, "_hi"}, 32'(rsp_hi), 32'(v.hi));
        chk({tag, "_lo"}, 32'(rsp_lo), 32'(v.lo));
        handshake();
        chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    vec_t vecs[5];
    logic        tie_id[3];
    logic [15:0] tie_lo[3];

    initial begin
        bit ok;
        int lat;
        bit seen;

        vecs[0] = '{id: 1'b0, a: 16'h1234, b: 16'h5678, hi: 16'h0626, lo: 16'h0060};
        vecs[1] = '{id: 1'b1, a: 16'hFFFF, b: 16'hFFFF, hi: 16'hFFFE, lo: 16'h0001};
        vecs[2] = '{id: 1'b0, a: 16'h00FF, b: 16'h0100, hi: 16'h0000, lo: 16'hFF00};
        vecs[3] = '{id: 1'b1, a: 16'h8000, b: 16'h0002, hi: 16'h0001, lo: 16'h0000};
        vecs[4] = '{id: 1'b1, a: 16'h0000, b: 16'hABCD, hi: 16'h0000, lo: 16'h0000};
        tie_id[0] = 1'b0; tie_lo[0] = 16'h000F;
        tie_id[1] = 1'b1; tie_lo[1] = 16'h003F;
        tie_id[2] = 1'b0; tie_lo[2] = 16'h000F;

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_hi", 32'(rsp_hi), 32'd0);
        chk("rst_lo", 32'(rsp_lo), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Tie from reset, both requesters held asserted throughout
        req0_a = 16'h0003; req0_b = 16'h0005;
        req1_a = 16'h0007; req1_b = 16'h0009;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("tie_one_hot", 32'(req0_ready & req1_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            wait_rsp(lat, ok);
            chk($sformatf("tie%0d_seen", k), 32'(ok), 32'd1);
            chk($sformatf("tie%0d_id", k), 32'(rsp_id), 32'(tie_id[k]));
            chk($sformatf("tie%0d_lo", k), 32'(rsp_lo), 32'(tie_lo[k]));
            chk($sformatf("tie%0d_hi", k), 32'(rsp_hi), 32'd0);
            handshake();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++)
            do_txn($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: result held, no new grant while DONE
        req0_a = 16'h0003; req0_b = 16'h0005; req0_valid = 1'b1;
        wait_ready(1'b0, ok);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_a = 16'h0007; req1_b = 16'h0009; req1_valid = 1'b1;
        wait_rsp(lat, ok);
        chk("bp_latency", 32'(lat), 32'(S));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_prod", c), {rsp_hi, rsp_lo}, 32'h0000_000F);
            chk($sformatf("bp%0d_id", c), 32'(rsp_id), 32'd0);
            chk($sformatf("bp%0d_readies", c), 32'({req0_ready, req1_ready}), 32'd0);
        end
        handshake();
        chk("bp_req1_ready_after", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_rsp(lat, ok);
        chk("bp_next_latency", 32'(lat), 32'(S));
        chk("bp_next_id", 32'(rsp_id), 32'd1);
        chk("bp_next_lo", 32'(rsp_lo), 32'h3F);
        handshake();

        // Reset during SETTLE discards the transaction
        req0_a = 16'h1234; req0_b = 16'h5678; req0_valid = 1'b1;
        wait_ready(1'b0, ok);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        chk("mr_busy_before", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(rsp_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_id", 32'(rsp_id), 32'd0);
        chk("mr_hi", 32'(rsp_hi), 32'd0);
        chk("mr_lo", 32'(rsp_lo), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("mr_no_rsp", 32'(seen), 32'd0);
        do_txn("mr_zero", '{id: 1'b0, a: 16'h0000, b: 16'h1234, hi: 16'h0000, lo: 16'h0000});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
